// File: rtl/seq_detect_fsm.sv
// Parametrised Moore sequence detector with a saturating match counter.
// Optional gap timeout is enabled by defining SEQ_DET_GAP_TIMEOUT_EN.
module seq_detect_fsm #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
`ifdef SEQ_DET_GAP_TIMEOUT_EN
  , parameter int               GAP_MAX = 15
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
`ifdef SEQ_DET_GAP_TIMEOUT_EN
  , output logic           timeout
`endif
);

  localparam int SW = $clog2(PAT_LEN + 1);
  localparam int NS = 2 ** SW;
  localparam logic [SW-1:0] S_IDLE  = '0;
  localparam logic [SW-1:0] S_MATCH = SW'(PAT_LEN);

  // Next state after holding s matched bits and receiving b (KMP fallback).
  function automatic int next_state(input int s, input logic b);
    int   res;
    int   kmax;
    int   j;
    bit   ok;
    logic hb;
    res = 0;
    if (s > PAT_LEN) begin
      return 0;
    end
    if (s == PAT_LEN && !OVERLAP) begin
      return (b == PATTERN[PAT_LEN-1]) ? 1 : 0;
    end
    kmax = (s + 1 > PAT_LEN) ? PAT_LEN : s + 1;
    for (int k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        j = k - 1 - i;
        if (j == 0) hb = b;
        else        hb = PATTERN[PAT_LEN-1-s+j];
        if (PATTERN[PAT_LEN-1-i] != hb) ok = 1'b0;
      end
      if (ok) res = k;
    end
    return res;
  endfunction

  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  for (genvar gi = 0; gi < NS; gi++) begin : g_tbl
    localparam int N0 = next_state(gi, 1'b0);
    localparam int N1 = next_state(gi, 1'b1);
    assign nxt0[gi] = SW'(N0);
    assign nxt1[gi] = SW'(N1);
  end

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, busy_q;
  logic             inc;

`ifdef SEQ_DET_GAP_TIMEOUT_EN
  localparam int GW = $clog2(GAP_MAX + 1);
  logic [GW-1:0] gap_q, gap_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    if (en) state_d = x ? nxt1[state_q] : nxt0[state_q];
`ifdef SEQ_DET_GAP_TIMEOUT_EN
    gap_d     = '0;
    timeout_d = 1'b0;
    if (!en && busy_q) begin
      if (gap_q == GW'(GAP_MAX - 1)) begin
        timeout_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
`endif
    inc   = en && (state_d == S_MATCH);
    cnt_d = cnt_q;
    // A clear coinciding with a match leaves exactly that match counted.
    if (clr_cnt)                  cnt_d = inc ? CNT_W'(1) : '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      y_q       <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SEQ_DET_GAP_TIMEOUT_EN
      gap_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= (state_d == S_MATCH);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_MATCH);
`ifdef SEQ_DET_GAP_TIMEOUT_EN
      gap_q     <= gap_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign y         = y_q;
  assign busy      = busy_q;
  assign match_cnt = cnt_q;
`ifdef SEQ_DET_GAP_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule
